// File: rtl/npc_pkg.sv
// Shared definitions for the NPC execution controller: FSM encoding and the
// architectural constants used at reset and for halt detection.
package npc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_EXEC  = 3'd3,
      ST_HALT  = 3'd4
   } npc_state_t;

   localparam logic [31:0] RESET_PC    = 32'h8000_0000;
   localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
   localparam logic [31:0] NOP_INST    = 32'h0000_0013;

endpackage

// File: rtl/npc_perf_cnt.sv
// Cycle and retired-instruction counters for the NPC core (built only when
// NPC_CTRL_PERF_EN is defined). Both wrap naturally at 2^64.
module npc_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        cyc_en,
   input  logic        ret_en,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instret_cnt
);

   always_ff @(posedge clk) begin
      if (!rst) begin
         cycle_cnt   <= 64'd0;
         instret_cnt <= 64'd0;
      end else begin
         if (cyc_en) cycle_cnt   <= cycle_cnt + 64'd1;
         if (ret_en) instret_cnt <= instret_cnt + 64'd1;
      end
   end

endmodule

// File: rtl/npc_exec_ctrl.sv
// Multi-cycle fetch/execute sequencer for the NPC core; owns the PC and gates
// regfile writes. Optional performance counters under NPC_CTRL_PERF_EN.
//
// state | meaning
// IDLE  | one cycle after reset before the first fetch
// FETCH | request outstanding on the ifu request channel
// WAIT  | request accepted, waiting for the response
// EXEC  | single execute cycle for the latched instruction
// HALT  | stopped (ebreak or fault); only reset leaves
module npc_exec_ctrl
   import npc_pkg::*;
#(
   parameter logic [31:0] P_RESET_PC    = RESET_PC,
   parameter logic [31:0] P_EBREAK_INST = EBREAK_INST,
   parameter logic [31:0] P_NOP_INST    = NOP_INST
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req_valid,
   output logic [31:0] ifu_req_addr,
   input  logic        ifu_req_ready,
   input  logic        ifu_rsp_valid,
   input  logic [31:0] ifu_rsp_inst,
   input  logic        ifu_rsp_err,
   output logic [31:0] inst,
   output logic [31:0] pc,
   input  logic [31:0] next_pc,
   input  logic        dec_reg_wen,
   output logic        rf_wen,
   output logic        ebreak_valid,
   output logic        halt,
   output logic        fault
`ifdef NPC_CTRL_PERF_EN
   ,
   output logic [63:0] cycle_cnt,
   output logic [63:0] instret_cnt
`endif
);

   npc_state_t state, state_nxt;
   logic       is_ebreak;
   logic       misaligned;
   logic       rsp_ok;
   logic       rsp_bad;

   assign is_ebreak    = (inst == P_EBREAK_INST);
   assign misaligned   = (next_pc[1:0] != 2'b00);
   assign rsp_ok       = (state == ST_WAIT) && ifu_rsp_valid && !ifu_rsp_err;
   assign rsp_bad      = (state == ST_WAIT) && ifu_rsp_valid && ifu_rsp_err;
   assign ifu_req_addr = pc;

   always_comb begin
      state_nxt     = state;
      ifu_req_valid = 1'b0;
      rf_wen        = 1'b0;
      ebreak_valid  = 1'b0;
      halt          = 1'b0;
      case (state)
         ST_IDLE:  state_nxt = ST_FETCH;
         ST_FETCH: begin
            ifu_req_valid = 1'b1;
            if (ifu_req_ready) state_nxt = ST_WAIT;
         end
         ST_WAIT: begin
            if (ifu_rsp_valid) state_nxt = ifu_rsp_err ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            // ebreak wins over a misaligned next_pc: the PC is not advanced either way
            if (is_ebreak) begin
               ebreak_valid = 1'b1;
               state_nxt    = ST_HALT;
            end else if (misaligned) begin
               state_nxt = ST_HALT;
            end else begin
               rf_wen    = dec_reg_wen;
               state_nxt = ST_FETCH;
            end
         end
         ST_HALT:  halt = 1'b1;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_IDLE;
         pc    <= P_RESET_PC;
         inst  <= P_NOP_INST;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         if (rsp_ok) inst <= ifu_rsp_inst;
         if (state == ST_EXEC && !is_ebreak && !misaligned) pc <= next_pc;
         if (rsp_bad || (state == ST_EXEC && !is_ebreak && misaligned)) fault <= 1'b1;
      end
   end

`ifdef NPC_CTRL_PERF_EN
   npc_perf_cnt u_perf_cnt (
      .clk         (clk),
      .rst         (rst),
      .cyc_en      (!halt),
      .ret_en      ((state == ST_EXEC) && (is_ebreak || !misaligned)),
      .cycle_cnt   (cycle_cnt),
      .instret_cnt (instret_cnt)
   );
`endif

endmodule

// File: tb/tb_npc_exec_ctrl.sv
// Self-checking bench for npc_exec_ctrl; counter checks are active when
// NPC_CTRL_PERF_EN is defined.
module tb_npc_exec_ctrl;
   import npc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ifu_req_valid;
   logic [31:0] ifu_req_addr;
   logic        ifu_req_ready = 1'b0;
   logic        ifu_rsp_valid = 1'b0;
   logic [31:0] ifu_rsp_inst  = 32'h0;
   logic        ifu_rsp_err   = 1'b0;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        dec_reg_wen   = 1'b1;
   logic        rf_wen;
   logic        ebreak_valid;
   logic        halt;
   logic        fault;
`ifdef NPC_CTRL_PERF_EN
   logic [63:0] cycle_cnt;
   logic [63:0] instret_cnt;
`endif

   logic [31:0] npc_ovr = 32'h0;
   logic        use_ovr = 1'b0;
   assign next_pc = use_ovr ? npc_ovr : pc + 32'd4;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];
   int          wen_cnt  = 0;
   longint      ref_cyc  = 0;

   npc_exec_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid),
      .ifu_req_addr  (ifu_req_addr),
      .ifu_req_ready (ifu_req_ready),
      .ifu_rsp_valid (ifu_rsp_valid),
      .ifu_rsp_inst  (ifu_rsp_inst),
      .ifu_rsp_err   (ifu_rsp_err),
      .inst          (inst),
      .pc            (pc),
      .next_pc       (next_pc),
      .dec_reg_wen   (dec_reg_wen),
      .rf_wen        (rf_wen),
      .ebreak_valid  (ebreak_valid),
      .halt          (halt),
      .fault         (fault)
`ifdef NPC_CTRL_PERF_EN
      ,
      .cycle_cnt     (cycle_cnt),
      .instret_cnt   (instret_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Reference: count write strobes and the cycles since reset release while running
   always @(posedge clk) begin
      if (rf_wen) wen_cnt <= wen_cnt + 1;
      if (!rst) ref_cyc <= 0;
      else if (!halt) ref_cyc <= ref_cyc + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      ifu_req_ready = 1'b0;
      ifu_rsp_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   // Drives one fetch; returns sampled in the EXEC cycle (or HALT on error)
   task automatic fetch_one(input logic [31:0] ins, input int rdy_stall, input int rsp_stall,
                            input logic err, output logic [31:0] acc_addr, output bit tmo);
      int n = 0;
      tmo = 1'b0;
      acc_addr = 32'h0;
      while (ifu_req_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (ifu_req_valid !== 1'b1) begin
         tmo = 1'b1;
         return;
      end
      repeat (rdy_stall) tick();
      acc_addr = ifu_req_addr;
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      repeat (rsp_stall) tick();
      ifu_rsp_valid = 1'b1;
      ifu_rsp_inst  = ins;
      ifu_rsp_err   = err;
      if (!err) exp_q.push_back(ins);
      tick();
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      rst = 1'b0;
      tick();
      n_checks++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 32'h8000_0000); end
      n_checks++; if (inst !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_inst: got %h want %h", inst, 32'h0000_0013); end
      n_checks++; if ({ifu_req_valid, rf_wen, ebreak_valid, halt, fault} !== 5'b0) begin
         n_fail++; $display("FAIL reset_outs: got %b want 00000", {ifu_req_valid, rf_wen, ebreak_valid, halt, fault}); end
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] a, e;
      bit          t;
      int          w0;
      w0 = wen_cnt;
      fetch_one(32'h0050_0093, 0, 0, 1'b0, a, t);
      n_checks++; if (t !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %0d want 0", t); end
      n_checks++; if (a !== 32'h8000_0000) begin n_fail++; $display("FAIL basic_addr: got %h want %h", a, 32'h8000_0000); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (inst !== e) begin n_fail++; $display("FAIL basic_inst: got %h want %h", inst, e); end
      n_checks++; if (rf_wen !== 1'b1) begin n_fail++; $display("FAIL basic_wen: got %b want 1", rf_wen); end
      tick();
      n_checks++; if ({rf_wen, ifu_req_valid} !== 2'b01) begin n_fail++; $display("FAIL basic_after: got %b want 01", {rf_wen, ifu_req_valid}); end
      n_checks++; if (pc !== 32'h8000_0004) begin n_fail++; $display("FAIL basic_pc: got %h want %h", pc, 32'h8000_0004); end
      n_checks++; if (wen_cnt - w0 !== 1) begin n_fail++; $display("FAIL basic_wen_cycles: got %0d want 1", wen_cnt - w0); end
   endtask

   task automatic test_stall();
      logic [31:0] a, e;
      bit          t;
      int          bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if ({ifu_req_valid, ifu_req_addr, rf_wen} !== {1'b1, 32'h8000_0004, 1'b0}) bad++;
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_stable: got %0d bad cycles want 0", bad); end
      dec_reg_wen = 1'b0;
      fetch_one(32'h0000_0013, 0, 2, 1'b0, a, t);
      n_checks++; if (t !== 1'b0) begin n_fail++; $display("FAIL stall_timeout: got %0d want 0", t); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (inst !== e) begin n_fail++; $display("FAIL stall_inst: got %h want %h", inst, e); end
      n_checks++; if (rf_wen !== 1'b0) begin n_fail++; $display("FAIL stall_wen: got %b want 0", rf_wen); end
      tick();
      n_checks++; if (pc !== 32'h8000_0008) begin n_fail++; $display("FAIL stall_pc: got %h want %h", pc, 32'h8000_0008); end
      dec_reg_wen = 1'b1;
   endtask

   task automatic test_ebreak();
      logic [31:0] a, e;
      bit          t;
      int          reqs = 0;
      fetch_one(32'h0010_0073, 1, 0, 1'b0, a, t);
      n_checks++; if (a !== 32'h8000_0008 || t !== 1'b0) begin n_fail++; $display("FAIL ebreak_addr: got %h want %h", a, 32'h8000_0008); end
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (inst !== e) begin n_fail++; $display("FAIL ebreak_inst: got %h want %h", inst, e); end
      n_checks++; if ({ebreak_valid, rf_wen} !== 2'b10) begin n_fail++; $display("FAIL ebreak_pulse: got %b want 10", {ebreak_valid, rf_wen}); end
      n_checks++; if (pc !== 32'h8000_0008) begin n_fail++; $display("FAIL ebreak_pc: got %h want %h", pc, 32'h8000_0008); end
      tick();
      n_checks++; if ({halt, fault, ebreak_valid} !== 3'b100) begin n_fail++; $display("FAIL ebreak_halt: got %b want 100", {halt, fault, ebreak_valid}); end
      for (int i = 0; i < 20; i++) begin
         tick();
         if (ifu_req_valid !== 1'b0) reqs++;
      end
      n_checks++; if (reqs !== 0) begin n_fail++; $display("FAIL ebreak_quiet: got %0d requests want 0", reqs); end
   endtask

   task automatic test_fetch_err();
      logic [31:0] a, e;
      bit          t;
      int          w0;
      do_reset();
      fetch_one(32'h00a0_0113, 0, 0, 1'b0, a, t);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (inst !== e || t !== 1'b0) begin n_fail++; $display("FAIL err_first_inst: got %h want %h", inst, e); end
      tick();
      w0 = wen_cnt;
      fetch_one(32'hdead_beef, 0, 1, 1'b1, a, t);
      n_checks++; if ({halt, fault} !== 2'b11 || t !== 1'b0) begin n_fail++; $display("FAIL err_halt: got %b want 11", {halt, fault}); end
      n_checks++; if (inst !== 32'h00a0_0113) begin n_fail++; $display("FAIL err_inst_kept: got %h want %h", inst, 32'h00a0_0113); end
      repeat (3) tick();
      n_checks++; if (wen_cnt !== w0) begin n_fail++; $display("FAIL err_no_wen: got %0d want %0d", wen_cnt, w0); end
   endtask

   task automatic test_misaligned();
      logic [31:0] a, e;
      bit          t;
      do_reset();
      use_ovr = 1'b1;
      npc_ovr = 32'h8000_0102;
      fetch_one(32'h0050_0093, 0, 0, 1'b0, a, t);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      n_checks++; if (inst !== e || t !== 1'b0) begin n_fail++; $display("FAIL mis_inst: got %h want %h", inst, e); end
      n_checks++; if ({rf_wen, ebreak_valid} !== 2'b00) begin n_fail++; $display("FAIL mis_wen: got %b want 00", {rf_wen, ebreak_valid}); end
      tick();
      n_checks++; if ({halt, fault} !== 2'b11) begin n_fail++; $display("FAIL mis_halt: got %b want 11", {halt, fault}); end
      n_checks++; if (pc !== 32'h8000_0000) begin n_fail++; $display("FAIL mis_pc: got %h want %h", pc, 32'h8000_0000); end
      use_ovr = 1'b0;
   endtask

   task automatic test_reset_in_wait_then_nops();
      logic [31:0] a, e;
      bit          t;
      int          n = 0;
      int          bad = 0;
      do_reset();
      while (ifu_req_valid !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      ifu_req_ready = 1'b1;
      tick();
      ifu_req_ready = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      n_checks++; if (pc !== 32'h8000_0000 || inst !== 32'h0000_0013) begin n_fail++; $display("FAIL rstwait_pc: got %h want %h", pc, 32'h8000_0000); end
      n_checks++; if ({ifu_req_valid, halt, fault} !== 3'b000) begin n_fail++; $display("FAIL rstwait_outs: got %b want 000", {ifu_req_valid, halt, fault}); end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         fetch_one(32'h0000_0013, 0, 0, 1'b0, a, t);
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
         if (t !== 1'b0 || inst !== e || a !== 32'h8000_0000 + 32'(4 * i)) bad++;
         tick();
      end
      n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL nops_seq: got %0d bad want 0", bad); end
      n_checks++; if (pc !== 32'h8000_0028) begin n_fail++; $display("FAIL nops_pc: got %h want %h", pc, 32'h8000_0028); end
`ifdef NPC_CTRL_PERF_EN
      n_checks++; if (instret_cnt !== 64'd10) begin n_fail++; $display("FAIL instret: got %0d want 10", instret_cnt); end
      n_checks++; if (cycle_cnt !== 64'(ref_cyc)) begin n_fail++; $display("FAIL cycle_cnt: got %0d want %0d", cycle_cnt, ref_cyc); end
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_ebreak();
      test_fetch_err();
      test_misaligned();
      test_reset_in_wait_then_nops();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
